// File: rtl/klavye_alici.sv
// PS/2 keyboard receiver: synchronizes and filters the PS/2 lines, frames bytes, decodes E0/F0 prefixes.
// Latency: karakter_aktif one clk after the stop-bit edge is detected; hata one clk after the error is seen.
// Backpressure: none; strobes are single-cycle and the receiver never stalls the keyboard.
module klavye_alici #(
    parameter int FILTRE_UZUNLUK = 8,
    parameter int ZAMAN_ASIMI    = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] karakter,
    output logic       karakter_aktif,
    output logic       genisletilmis,
    output logic       hata
);
    localparam int FW = $clog2(FILTRE_UZUNLUK + 1);
    localparam int TW = $clog2(ZAMAN_ASIMI + 1);
    localparam logic [FW-1:0] FILTRE_SON = FW'(FILTRE_UZUNLUK - 1);
    localparam logic [TW-1:0] TMO_SON    = TW'(ZAMAN_ASIMI - 1);

    typedef enum logic [1:0] {BOSTA, VERI, PARITE, DUR} durum_t;

    durum_t      durum, durum_n;
    logic        ps2_clk_s1, ps2_clk_s2, ps2_data_s1, ps2_data_s2;
    logic        ps2_clk_filt;
    logic [FW-1:0] filt_say;
    logic [TW-1:0] tmo_say;
    logic [2:0]  bit_say, bit_say_n;
    logic [7:0]  kaydir, kaydir_n;
    logic        parite_iyi, parite_iyi_n;
    logic        kirma, kirma_n, genis_bayrak, genis_bayrak_n;
    logic [7:0]  karakter_n;
    logic        aktif_n, genisletilmis_n, hata_n;
    logic        dusen, zaman_doldu, veri;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps2_clk_s1  <= 1'b1;
            ps2_clk_s2  <= 1'b1;
            ps2_data_s1 <= 1'b1;
            ps2_data_s2 <= 1'b1;
        end else begin
            ps2_clk_s1  <= ps2_clk;
            ps2_clk_s2  <= ps2_clk_s1;
            ps2_data_s1 <= ps2_data;
            ps2_data_s2 <= ps2_data_s1;
        end
    end

    // The filtered clock flips on the last of FILTRE_UZUNLUK agreeing samples; that cycle is the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps2_clk_filt <= 1'b1;
            filt_say     <= '0;
        end else if (ps2_clk_s2 != ps2_clk_filt) begin
            if (filt_say == FILTRE_SON) begin
                ps2_clk_filt <= ps2_clk_s2;
                filt_say     <= '0;
            end else begin
                filt_say <= filt_say + 1'b1;
            end
        end else begin
            filt_say <= '0;
        end
    end

    assign dusen       = ps2_clk_filt && !ps2_clk_s2 && (filt_say == FILTRE_SON);
    assign veri        = ps2_data_s2;
    assign zaman_doldu = (durum != BOSTA) && (tmo_say == TMO_SON);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tmo_say <= '0;
        else if (durum == BOSTA || dusen)
            tmo_say <= '0;
        else if (tmo_say != TMO_SON)
            tmo_say <= tmo_say + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            durum          <= BOSTA;
            bit_say        <= '0;
            kaydir         <= '0;
            parite_iyi     <= 1'b0;
            kirma          <= 1'b0;
            genis_bayrak   <= 1'b0;
            karakter       <= '0;
            karakter_aktif <= 1'b0;
            genisletilmis  <= 1'b0;
            hata           <= 1'b0;
        end else begin
            durum          <= durum_n;
            bit_say        <= bit_say_n;
            kaydir         <= kaydir_n;
            parite_iyi     <= parite_iyi_n;
            kirma          <= kirma_n;
            genis_bayrak   <= genis_bayrak_n;
            karakter       <= karakter_n;
            karakter_aktif <= aktif_n;
            genisletilmis  <= genisletilmis_n;
            hata           <= hata_n;
        end
    end

    always_comb begin
        durum_n         = durum;
        bit_say_n       = bit_say;
        kaydir_n        = kaydir;
        parite_iyi_n    = parite_iyi;
        kirma_n         = kirma;
        genis_bayrak_n  = genis_bayrak;
        karakter_n      = karakter;
        genisletilmis_n = genisletilmis;
        aktif_n         = 1'b0;
        hata_n          = 1'b0;
        // Timeout wins over a coincident edge, which is then ignored.
        if (zaman_doldu) begin
            durum_n        = BOSTA;
            hata_n         = 1'b1;
            kirma_n        = 1'b0;
            genis_bayrak_n = 1'b0;
        end else if (dusen) begin
            case (durum)
                BOSTA: begin
                    if (!veri) begin
                        durum_n   = VERI;
                        bit_say_n = '0;
                    end
                end
                VERI: begin
                    kaydir_n  = {veri, kaydir[7:1]};
                    bit_say_n = bit_say + 3'd1;
                    if (bit_say == 3'd7)
                        durum_n = PARITE;
                end
                PARITE: begin
                    parite_iyi_n = ^{veri, kaydir};
                    durum_n      = DUR;
                end
                DUR: begin
                    durum_n = BOSTA;
                    if (veri && parite_iyi) begin
                        if (kaydir == 8'hF0) begin
                            kirma_n = 1'b1;
                        end else if (kaydir == 8'hE0) begin
                            genis_bayrak_n = 1'b1;
                        end else begin
                            if (!kirma) begin
                                karakter_n      = kaydir;
                                genisletilmis_n = genis_bayrak;
                                aktif_n         = 1'b1;
                            end
                            kirma_n        = 1'b0;
                            genis_bayrak_n = 1'b0;
                        end
                    end else begin
                        hata_n         = 1'b1;
                        kirma_n        = 1'b0;
                        genis_bayrak_n = 1'b0;
                    end
                end
                default: durum_n = BOSTA;
            endcase
        end
    end
endmodule

// File: tb/tb_klavye_alici.sv
// Bench for klavye_alici: directed and random PS/2 frames checked against a byte-level decoder model.
module tb_klavye_alici;
    localparam int N   = 4;
    localparam int TMO = 300;
    localparam int H   = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] karakter;
    logic       karakter_aktif, genisletilmis, hata;

    klavye_alici #(.FILTRE_UZUNLUK(N), .ZAMAN_ASIMI(TMO)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .karakter(karakter), .karakter_aktif(karakter_aktif),
        .genisletilmis(genisletilmis), .hata(hata)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int cyc = 0, stop_cyc = 0, aktif_cyc = 0;
    int aktif_say = 0, hata_say = 0, ikisi = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (karakter_aktif) begin
                aktif_say <= aktif_say + 1;
                aktif_cyc <= cyc;
            end
            if (hata) hata_say <= hata_say + 1;
            if (hata && karakter_aktif) ikisi <= ikisi + 1;
        end
    end

    // Reference decoder state
    logic [7:0] m_kar = 8'h00;
    logic       m_gen = 1'b0, m_brk = 1'b0, m_ext = 1'b0;
    int         e_strobe, e_hata, a0, h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model(input logic [7:0] b, input logic err);
        e_strobe = 0;
        e_hata   = 0;
        if (err) begin
            e_hata = 1; m_brk = 1'b0; m_ext = 1'b0;
        end else if (b == 8'hF0) m_brk = 1'b1;
        else if (b == 8'hE0) m_ext = 1'b1;
        else begin
            if (!m_brk) begin
                m_kar = b; m_gen = m_ext; e_strobe = 1;
            end
            m_brk = 1'b0; m_ext = 1'b0;
        end
    endtask

    task automatic frame(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                         input int nbits, input int glitch);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        a0 = aktif_say;
        h0 = hata_say;
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            if (i == glitch) begin
                wait_cyc(H/2); ps2_clk = 1'b0; wait_cyc(2); ps2_clk = 1'b1; wait_cyc(H/2 - 2);
            end else wait_cyc(H);
            ps2_clk  = 1'b0;
            stop_cyc = cyc;
            if (i == glitch) begin
                wait_cyc(H/2); ps2_clk = 1'b1; wait_cyc(2); ps2_clk = 1'b0; wait_cyc(H/2 - 2);
            end else wait_cyc(H);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic check_frame(input string tag);
        wait_cyc(3*H);
        chk({tag, ".strobe"}, aktif_say - a0, e_strobe);
        chk({tag, ".hata"}, hata_say - h0, e_hata);
        chk({tag, ".karakter"}, {24'h0, karakter}, {24'h0, m_kar});
        chk({tag, ".genis"}, {31'h0, genisletilmis}, {31'h0, m_gen});
        if (e_strobe == 1) chk({tag, ".latency"}, aktif_cyc - stop_cyc, N + 2);
    endtask

    task automatic full(input string tag, input logic [7:0] b, input logic bp, input logic bs, input int g);
        frame(b, bp, bs, 11, g);
        model(b, bp | bs);
        check_frame(tag);
    endtask

    initial begin
        logic [7:0] rb;
        int r, e;
        wait_cyc(3);
        chk("rst.karakter", {24'h0, karakter}, 32'h0);
        chk("rst.strobes", {29'h0, karakter_aktif, genisletilmis, hata}, 32'h0);
        rst = 1'b0;
        wait_cyc(10);

        full("f1C", 8'h1C, 1'b0, 1'b0, -1);
        full("brkF0", 8'hF0, 1'b0, 1'b0, -1);
        full("brk1C", 8'h1C, 1'b0, 1'b0, -1);
        full("extE0", 8'hE0, 1'b0, 1'b0, -1);
        full("ext75", 8'h75, 1'b0, 1'b0, -1);
        full("e2E0", 8'hE0, 1'b0, 1'b0, -1);
        full("e2F0", 8'hF0, 1'b0, 1'b0, -1);
        full("e275", 8'h75, 1'b0, 1'b0, -1);
        full("badpar", 8'h1C, 1'b1, 1'b0, -1);
        full("after32", 8'h32, 1'b0, 1'b0, -1);
        full("badstop", 8'h44, 1'b0, 1'b1, -1);

        // E0 then a timed-out partial frame must leave the extended flag cleared.
        full("toE0", 8'hE0, 1'b0, 1'b0, -1);
        frame(8'h75, 1'b0, 1'b0, 5, -1);
        wait_cyc(TMO + 100);
        model(8'h00, 1'b1);
        chk("timeout.hata", hata_say - h0, 1);
        chk("timeout.strobe", aktif_say - a0, 0);
        full("to75", 8'h75, 1'b0, 1'b0, -1);

        full("glitch5A", 8'h5A, 1'b0, 1'b0, 3);
        full("glitch2B", 8'h2B, 1'b0, 1'b0, 7);

        // Reset in the middle of a frame
        frame(8'h3C, 1'b0, 1'b0, 5, -1);
        rst = 1'b1;
        wait_cyc(5);
        chk("midrst.karakter", {24'h0, karakter}, 32'h0);
        chk("midrst.strobes", {29'h0, karakter_aktif, genisletilmis, hata}, 32'h0);
        rst = 1'b0;
        m_kar = 8'h00; m_gen = 1'b0; m_brk = 1'b0; m_ext = 1'b0;
        wait_cyc(20);
        chk("midrst.nostrobe", aktif_say - a0, 0);
        full("postrst1C", 8'h1C, 1'b0, 1'b0, -1);

        for (int i = 0; i < 24; i++) begin
            r = $urandom_range(0, 9);
            e = $urandom_range(0, 9);
            rb = (r == 0) ? 8'hF0 : (r == 1) ? 8'hE0 : 8'($urandom_range(0, 255));
            full($sformatf("rnd%0d", i), rb, e == 0, e == 1, -1);
        end

        chk("never_both", ikisi, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
